// File: rtl/pe_enable_stack_pkg.sv
// Shared enable-op encodings for the PE enable stack and the decoder that issues them.
package pe_enable_stack_pkg;

    localparam int unsigned ENOP_W = 3;

    // Codes 6 and 7 are unassigned and behave as NOP.
    typedef enum logic [ENOP_W-1:0] {
        ENOP_NOP    = 3'd0,
        ENOP_ALLEN  = 3'd1,
        ENOP_PUSHEN = 3'd2,
        ENOP_POPEN  = 3'd3,
        ENOP_CLRIF  = 3'd4,
        ENOP_ELSEN  = 3'd5
    } enop_e;

endpackage

// File: rtl/pe_enable_stack_if.sv
// Op/condition inputs and enable/status outputs of the PE enable stack.
interface pe_enable_stack_if
    import pe_enable_stack_pkg::*;
#(
    parameter int unsigned NPE   = 4,
    parameter int unsigned DEPTH = 32,
    parameter int unsigned DW    = $clog2(DEPTH)
);
    logic              hold;
    logic [ENOP_W-1:0] op;
    logic [NPE-1:0]    czero;
    logic [NPE-1:0]    en;
    logic              any_en;
    logic [DW-1:0]     depth;
    logic              ovf;
    logic              unf;

    modport master (
        output hold, op, czero,
        input  en, any_en, depth, ovf, unf
    );

    modport slave (
        input  hold, op, czero,
        output en, any_en, depth, ovf, unf
    );

endinterface

// File: rtl/pe_enable_stack_en_lane.sv
// One PE lane's enable stack; the depth pointer is owned by the parent and shared by all lanes.
module pe_enable_stack_en_lane
    import pe_enable_stack_pkg::*;
#(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned DW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hold,
    input  logic [ENOP_W-1:0] op,
    input  logic              czero,
    input  logic [DW-1:0]     depth,
    output logic              top
);

    logic [DEPTH-1:0] stk_q, stk_d;
    logic             top_bit;
    logic             parent_bit;
    logic             full;

    always_comb begin
        top_bit    = stk_q[depth];
        // The base entry has an implicit always-enabled parent.
        parent_bit = (depth == '0) ? 1'b1 : stk_q[depth - DW'(1)];
        full       = (depth == DW'(DEPTH - 1));
    end

    always_comb begin
        stk_d = stk_q;
        if (!hold) begin
            case (op)
                ENOP_ALLEN:  stk_d[depth] = 1'b1;
                ENOP_PUSHEN: if (!full) stk_d[depth + DW'(1)] = top_bit;
                ENOP_CLRIF:  if (czero) stk_d[depth] = 1'b0;
                ENOP_ELSEN:  stk_d[depth] = ~top_bit & parent_bit;
                default:     ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stk_q <= '1;
        end else begin
            stk_q <= stk_d;
        end
    end

    assign top = top_bit;

endmodule

// File: rtl/pe_enable_stack.sv
// Per-lane SIMD enable-mask stacks with a shared depth pointer and sticky overflow/underflow.
module pe_enable_stack
    import pe_enable_stack_pkg::*;
#(
    parameter int unsigned NPE   = 4,
    parameter int unsigned DEPTH = 32,
    parameter int unsigned DW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    pe_enable_stack_if.slave  bus
);

    logic [DW-1:0]  depth_q, depth_d;
    logic           ovf_q, ovf_d;
    logic           unf_q, unf_d;
    logic [NPE-1:0] lane_top;

    always_comb begin
        depth_d = depth_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        if (!bus.hold) begin
            case (bus.op)
                ENOP_PUSHEN: begin
                    if (depth_q == DW'(DEPTH - 1)) ovf_d = 1'b1;
                    else                           depth_d = depth_q + DW'(1);
                end
                ENOP_POPEN: begin
                    if (depth_q == '0) unf_d = 1'b1;
                    else               depth_d = depth_q - DW'(1);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Lanes see the pre-update depth so push/pop and top writes land on the current level.
    for (genvar i = 0; i < NPE; i++) begin : g_lane
        pe_enable_stack_en_lane #(
            .DEPTH (DEPTH),
            .DW    (DW)
        ) u_lane (
            .clk   (clk),
            .reset (reset),
            .hold  (bus.hold),
            .op    (bus.op),
            .czero (bus.czero[i]),
            .depth (depth_q),
            .top   (lane_top[i])
        );
    end

    assign bus.en     = lane_top;
    assign bus.any_en = |lane_top;
    assign bus.depth  = depth_q;
    assign bus.ovf    = ovf_q;
    assign bus.unf    = unf_q;

endmodule

// File: tb/tb_pe_enable_stack.sv
// Scoreboard bench for pe_enable_stack with NPE=4, DEPTH=4.
module tb_pe_enable_stack;
    import pe_enable_stack_pkg::*;

    localparam int unsigned NPE   = 4;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned DW    = 2;

    typedef struct {
        logic [NPE-1:0] en;
        logic           any_en;
        logic [DW-1:0]  depth;
        logic           ovf;
        logic           unf;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    pe_enable_stack_if #(.NPE(NPE), .DEPTH(DEPTH), .DW(DW)) bus ();

    pe_enable_stack #(.NPE(NPE), .DEPTH(DEPTH), .DW(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    exp_t sb[$];

    // Reference model state
    logic m_stk [NPE][DEPTH];
    int   m_depth;
    logic m_ovf, m_unf;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic h, input logic [2:0] o,
                              input logic [NPE-1:0] cz);
        logic par;
        if (r) begin
            for (int i = 0; i < NPE; i++)
                for (int j = 0; j < DEPTH; j++) m_stk[i][j] = 1'b1;
            m_depth = 0;
            m_ovf   = 1'b0;
            m_unf   = 1'b0;
        end else if (!h) begin
            case (o)
                3'd1: for (int i = 0; i < NPE; i++) m_stk[i][m_depth] = 1'b1;
                3'd2: begin
                    if (m_depth == DEPTH - 1) m_ovf = 1'b1;
                    else begin
                        for (int i = 0; i < NPE; i++) m_stk[i][m_depth+1] = m_stk[i][m_depth];
                        m_depth++;
                    end
                end
                3'd3: begin
                    if (m_depth == 0) m_unf = 1'b1;
                    else              m_depth--;
                end
                3'd4: for (int i = 0; i < NPE; i++) if (cz[i]) m_stk[i][m_depth] = 1'b0;
                3'd5: for (int i = 0; i < NPE; i++) begin
                    par = (m_depth == 0) ? 1'b1 : m_stk[i][m_depth-1];
                    m_stk[i][m_depth] = ~m_stk[i][m_depth] & par;
                end
                default: ;
            endcase
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        for (int i = 0; i < NPE; i++) e.en[i] = m_stk[i][m_depth];
        e.any_en = |e.en;
        e.depth  = DW'(m_depth);
        e.ovf    = m_ovf;
        e.unf    = m_unf;
        return e;
    endfunction

    // Drive one cycle, predict, then compare after the edge.
    task automatic step(input logic r, input logic h, input logic [2:0] o,
                        input logic [NPE-1:0] cz);
        exp_t e;
        @(negedge clk);
        reset     = r;
        bus.hold  = h;
        bus.op    = o;
        bus.czero = cz;
        model_step(r, h, o, cz);
        sb.push_back(model_out());
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("en",     32'(bus.en),     32'(e.en));
        check("any_en", 32'(bus.any_en), 32'(e.any_en));
        check("depth",  32'(bus.depth),  32'(e.depth));
        check("ovf",    32'(bus.ovf),    32'(e.ovf));
        check("unf",    32'(bus.unf),    32'(e.unf));
    endtask

    initial begin
        reset     = 1'b1;
        bus.hold  = 1'b0;
        bus.op    = ENOP_NOP;
        bus.czero = '0;
        m_depth   = 0;
        m_ovf     = 1'b0;
        m_unf     = 1'b0;
        for (int i = 0; i < NPE; i++)
            for (int j = 0; j < DEPTH; j++) m_stk[i][j] = 1'b0;

        // Reset then NOPs
        step(1'b1, 1'b0, ENOP_NOP, 4'b0000);
        check("rst_en", 32'(bus.en), 32'hF);
        check("rst_any", 32'(bus.any_en), 32'd1);
        check("rst_depth", 32'(bus.depth), 32'd0);
        for (int k = 0; k < 5; k++) step(1'b0, 1'b0, ENOP_NOP, 4'b1111);
        check("nop_en", 32'(bus.en), 32'hF);

        // Single level if/else
        step(1'b0, 1'b0, ENOP_PUSHEN, 4'b0000);
        step(1'b0, 1'b0, ENOP_CLRIF, 4'b0101);
        check("clrif_en", 32'(bus.en), 32'hA);
        step(1'b0, 1'b0, ENOP_ELSEN, 4'b0000);
        check("else_en", 32'(bus.en), 32'h5);
        step(1'b0, 1'b0, ENOP_POPEN, 4'b0000);
        check("pop_en", 32'(bus.en), 32'hF);
        check("pop_depth", 32'(bus.depth), 32'd0);

        // Nested: parent masks the inner else
        step(1'b0, 1'b0, ENOP_PUSHEN, 4'b0000);
        step(1'b0, 1'b0, ENOP_CLRIF, 4'b0011);
        check("nest_clr", 32'(bus.en), 32'hC);
        step(1'b0, 1'b0, ENOP_PUSHEN, 4'b0000);
        step(1'b0, 1'b0, ENOP_ELSEN, 4'b0000);
        check("nest_else", 32'(bus.en), 32'h0);
        check("nest_any", 32'(bus.any_en), 32'd0);
        step(1'b0, 1'b0, ENOP_POPEN, 4'b0000);
        step(1'b0, 1'b0, ENOP_POPEN, 4'b0000);
        check("nest_pop", 32'(bus.en), 32'hF);

        // Overflow; unassigned codes act as NOP
        step(1'b0, 1'b0, ENOP_CLRIF, 4'b0001);
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0, ENOP_PUSHEN, 4'b0000);
        check("ovf_depth", 32'(bus.depth), 32'd3);
        check("ovf_flag", 32'(bus.ovf), 32'd1);
        check("ovf_en", 32'(bus.en), 32'hE);
        step(1'b0, 1'b0, 3'd6, 4'b1111);
        step(1'b0, 1'b0, 3'd7, 4'b1111);
        step(1'b0, 1'b0, ENOP_ALLEN, 4'b0000);
        check("ovf_allen", 32'(bus.en), 32'hF);
        step(1'b1, 1'b0, ENOP_NOP, 4'b0000);
        check("ovf_rst", 32'(bus.ovf), 32'd0);

        // Underflow and hold
        step(1'b0, 1'b0, ENOP_POPEN, 4'b0000);
        check("unf_flag", 32'(bus.unf), 32'd1);
        check("unf_depth", 32'(bus.depth), 32'd0);
        step(1'b0, 1'b1, ENOP_CLRIF, 4'b1111);
        check("hold_en", 32'(bus.en), 32'hF);
        step(1'b0, 1'b1, ENOP_PUSHEN, 4'b1111);
        step(1'b1, 1'b1, ENOP_NOP, 4'b0000);
        check("rst_hold_unf", 32'(bus.unf), 32'd0);

        // Reset mid-nest
        step(1'b0, 1'b0, ENOP_PUSHEN, 4'b0000);
        step(1'b0, 1'b0, ENOP_CLRIF, 4'b1111);
        step(1'b0, 1'b0, ENOP_PUSHEN, 4'b0000);
        check("mid_depth", 32'(bus.depth), 32'd2);
        check("mid_en", 32'(bus.en), 32'h0);
        step(1'b1, 1'b0, ENOP_NOP, 4'b0000);
        check("mid_rst_en", 32'(bus.en), 32'hF);
        check("mid_rst_depth", 32'(bus.depth), 32'd0);

        // Random ops with occasional hold and reset
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(0, 59) == 0), ($urandom_range(0, 7) == 0),
                 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
        end

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
